rr_grant_arbiter: RTL and testbench

RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

---
 rtl/rr_grant_arbiter.sv | 127 ++++++++++++
 tb/tb_rr_grant_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - registered round-robin / fixed-priority grant arbiter.
// Define ARB_BLOCK_ACK_EN to hold each grant until acknowledge[grant_encoded] pulses.
module rr_grant_arbiter #(
  parameter int    PORTS                = 4,
  parameter int    ARB_TYPE_ROUND_ROBIN = 1,
  parameter string LSB_PRIORITY         = "LOW",
  localparam int   EW                   = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [EW-1:0]    grant_encoded
);

  localparam bit MSB_FIRST = (LSB_PRIORITY == "HIGH");
  localparam bit RR_MODE   = (ARB_TYPE_ROUND_ROBIN != 0);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  state_t state_q, state_n;

  // mask_q marks the ports that come strictly after the last grant in priority order
  logic [PORTS-1:0] mask_q, mask_n;
  logic [PORTS-1:0] grant_n;
  logic [EW-1:0]    enc_n;

  logic [PORTS-1:0] masked_req;
  logic [PORTS-1:0] pick_src;
  logic [EW-1:0]    sel_idx;
  logic [PORTS-1:0] sel_onehot;
  logic [PORTS-1:0] sel_mask;
  logic             any_req;
  logic             release_now;

  assign any_req = |request;

  always_comb begin
    masked_req = request & mask_q;
    pick_src   = (RR_MODE && (masked_req != '0)) ? masked_req : request;
    sel_idx    = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < PORTS; i++) begin
        if (pick_src[i]) sel_idx = EW'(i);
      end
    end else begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (pick_src[i]) sel_idx = EW'(i);
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    sel_mask   = '0;
    for (int i = 0; i < PORTS; i++) begin
      sel_onehot[i] = (EW'(i) == sel_idx);
      sel_mask[i]   = MSB_FIRST ? (EW'(i) < sel_idx) : (EW'(i) > sel_idx);
    end
  end

`ifdef ARB_BLOCK_ACK_EN
  assign release_now = acknowledge[grant_encoded];
`else
  logic unused_ack;
  assign unused_ack  = ^acknowledge;
  assign release_now = ~request[grant_encoded];
`endif

  always_comb begin
    state_n = state_q;
    grant_n = grant;
    enc_n   = grant_encoded;
    mask_n  = mask_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_n = GRANTED;
          grant_n = sel_onehot;
          enc_n   = sel_idx;
          mask_n  = sel_mask;
        end
      end
      GRANTED: begin
        // a release hands straight over to the next requester without an idle cycle
        if (release_now) begin
          if (any_req) begin
            grant_n = sel_onehot;
            enc_n   = sel_idx;
            mask_n  = sel_mask;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            enc_n   = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        enc_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant         <= '0;
      grant_encoded <= '0;
      mask_q        <= '0;
    end else begin
      state_q       <= state_n;
      grant         <= grant_n;
      grant_encoded <= enc_n;
      mask_q        <= mask_n;
    end
  end

  assign grant_valid = (state_q == GRANTED);

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - bench for rr_grant_arbiter (RR low, fixed low, RR high instances).
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] request = 4'b0;
  logic [3:0] acknowledge = 4'b0;

  logic [3:0] g  [3];
  logic       gv [3];
  logic [1:0] ge [3];

  int vectors = 0;
  int miscompares = 0;

  bit m_valid [3];
  int m_idx   [3];
  int m_last  [3];

  always #5 clk = ~clk;

  rr_grant_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .LSB_PRIORITY("LOW")) u_rr (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g[0]), .grant_valid(gv[0]), .grant_encoded(ge[0]));

  rr_grant_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .LSB_PRIORITY("LOW")) u_fp (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g[1]), .grant_valid(gv[1]), .grant_encoded(ge[1]));

  rr_grant_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .LSB_PRIORITY("HIGH")) u_hi (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g[2]), .grant_valid(gv[2]), .grant_encoded(ge[2]));

  function automatic bit is_rr(int d);
    return d != 1;
  endfunction

  function automatic bit is_high(int d);
    return d == 2;
  endfunction

  // Rank of each requester in rotated priority order; smallest rank wins.
  function automatic int pick(int d, logic [3:0] r);
    int best = -1;
    int best_key = 1000;
    int p, lp, key;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        p = is_high(d) ? 3 - i : i;
        if (is_rr(d) && m_last[d] >= 0) begin
          lp  = is_high(d) ? 3 - m_last[d] : m_last[d];
          key = (p - lp - 1 + 8) % 4;
        end else begin
          key = p;
        end
        if (key < best_key) begin
          best_key = key;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic step();
    bit rel;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_valid[d] = 1'b0;
        m_idx[d]   = 0;
        m_last[d]  = -1;
      end else begin
`ifdef ARB_BLOCK_ACK_EN
        rel = m_valid[d] && acknowledge[m_idx[d]];
`else
        rel = m_valid[d] && !request[m_idx[d]];
`endif
        if (!m_valid[d] || rel) begin
          if (request != 4'b0) begin
            m_idx[d]   = pick(d, request);
            m_last[d]  = m_idx[d];
            m_valid[d] = 1'b1;
          end else begin
            m_valid[d] = 1'b0;
            m_idx[d]   = 0;
          end
        end
      end
    end
  endtask

  task automatic check_models(string tag);
    logic [3:0] exp_g;
    logic [1:0] exp_e;
    for (int d = 0; d < 3; d++) begin
      exp_g = m_valid[d] ? (4'b0001 << m_idx[d]) : 4'b0000;
      exp_e = m_valid[d] ? 2'(m_idx[d]) : 2'd0;
      vectors++;
      if ({g[d], gv[d], ge[d]} !== {exp_g, m_valid[d], exp_e}) begin
        miscompares++;
        $display("FAIL %s dut%0d: got grant=%b valid=%b enc=%0d, expected grant=%b valid=%b enc=%0d",
                 tag, d, g[d], gv[d], ge[d], exp_g, m_valid[d], exp_e);
      end
      vectors++;
      if ($countones(g[d]) > 1 || gv[d] !== (g[d] != 4'b0)) begin
        miscompares++;
        $display("FAIL %s_invariant dut%0d: got grant=%b valid=%b, expected one-hot/zero with valid==|grant",
                 tag, d, g[d], gv[d]);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; request = 4'b0; acknowledge = 4'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    request = 4'($urandom_range(1, 15));
    acknowledge = 4'b0;
    step();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({g[d], gv[d], ge[d]} !== 7'b0) begin
        miscompares++;
        $display("FAIL reset dut%0d: got grant=%b valid=%b enc=%0d, expected all zero", d, g[d], gv[d], ge[d]);
      end
    end
    rst = 1'b0;
    request = 4'b0;
    step();
    check_models("reset_idle");
  endtask

  task automatic test_rr_sequence();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    request = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (ge[0] !== 2'(exp_seq[k]) || gv[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL rr_seq step%0d: got enc=%0d valid=%b, expected enc=%0d valid=1", k, ge[0], gv[0], exp_seq[k]);
      end
      check_models("rr_seq");
      request = 4'b1111 & ~(4'b0001 << exp_seq[k]);
      acknowledge = 4'b0001 << exp_seq[k];
      if (k < 4) step();
    end
    acknowledge = 4'b0;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    request = 4'b1010;
    step();
    vectors++;
    if (g[1] !== 4'b0010) begin
      miscompares++;
      $display("FAIL fixed_first: got grant=%b, expected 0010", g[1]);
    end
    check_models("fixed_first");
    request = 4'b1000;
    acknowledge = 4'b0010;
    step();
    vectors++;
    if (g[1] !== 4'b1000) begin
      miscompares++;
      $display("FAIL fixed_handover: got grant=%b, expected 1000", g[1]);
    end
    check_models("fixed_handover");
    acknowledge = 4'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    request = 4'b1000;
    step();
    check_models("wrap_setup");
    request = 4'b0101;
    acknowledge = 4'b1000;
    step();
    vectors++;
    if (ge[0] !== 2'd0 || gv[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap: got enc=%0d valid=%b, expected enc=0 valid=1", ge[0], gv[0]);
    end
    check_models("wrap");
    acknowledge = 4'b0;
  endtask

  task automatic test_acknowledge();
    do_reset();
    request = 4'b0100;
    step();
    check_models("ack_setup");
`ifdef ARB_BLOCK_ACK_EN
    request = 4'b0000;
    acknowledge = 4'b0001;
    step();
    vectors++;
    if (g[0] !== 4'b0100) begin
      miscompares++;
      $display("FAIL ack_hold: got grant=%b, expected 0100", g[0]);
    end
    check_models("ack_hold");
    acknowledge = 4'b0100;
    step();
    vectors++;
    if (g[0] !== 4'b0000 || gv[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_release: got grant=%b valid=%b, expected 0000 valid=0", g[0], gv[0]);
    end
    check_models("ack_release");
`else
    acknowledge = 4'b0100;
    step();
    vectors++;
    if (g[0] !== 4'b0100) begin
      miscompares++;
      $display("FAIL ack_ignored: got grant=%b, expected 0100", g[0]);
    end
    check_models("ack_ignored");
    request = 4'b0000;
    acknowledge = 4'b0000;
    step();
    vectors++;
    if (g[0] !== 4'b0000 || gv[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL req_release: got grant=%b valid=%b, expected 0000 valid=0", g[0], gv[0]);
    end
    check_models("req_release");
`endif
    acknowledge = 4'b0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    request = 4'b0100;
    step();
    check_models("midrst_setup");
    request = 4'b1111;
    rst = 1'b1;
    step();
    vectors++;
    if ({g[0], gv[0], ge[0]} !== 7'b0) begin
      miscompares++;
      $display("FAIL midrst_zero: got grant=%b valid=%b enc=%0d, expected all zero", g[0], gv[0], ge[0]);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (g[0] !== 4'b0001) begin
      miscompares++;
      $display("FAIL midrst_regrant: got grant=%b, expected 0001", g[0]);
    end
    check_models("midrst_regrant");
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) == 0) request = 4'($urandom_range(0, 15));
      acknowledge = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      step();
      check_models("random");
    end
    rst = 1'b0;
    request = 4'b0;
    acknowledge = 4'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_valid[d] = 1'b0;
      m_idx[d]   = 0;
      m_last[d]  = -1;
    end
    test_reset();
    test_rr_sequence();
    test_fixed_priority();
    test_wrap();
    test_acknowledge();
    test_reset_mid_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
